pipe_mem_arb: RTL and testbench
===============================

# pipe_mem_arb

Two-master memory arbiter that shares the core's single memory port between the instruction fetch unit (IFU) and the load/store unit in the EX stage. It accepts one request at a time, forwards it to the memory port, and returns the response to the owning master. All three sides use valid/ready handshakes. A pipeline flush discards any in-flight IFU response without disturbing the bus protocol.

## Interface
Parameters:
- ADDR_W, 32, address width (matches paddr_t)
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; cancels the IFU transaction
- ifu_req_valid_i / ifu_req_ready_o  in/out  1  IFU request handshake
- ifu_req_addr_i  in  ADDR_W  fetch address
- ifu_rsp_valid_o / ifu_rsp_ready_i  out/in  1  IFU response handshake
- ifu_rsp_data_o  out  DATA_W  fetched word
- lsu_req_valid_i / lsu_req_ready_o  in/out  1  LSU request handshake
- lsu_req_addr_i  in  ADDR_W  load/store address
- lsu_req_we_i  in  1  1 = store
- lsu_req_wdata_i  in  DATA_W  store data
- lsu_req_wstrb_i  in  DATA_W/8  byte strobes
- lsu_rsp_valid_o / lsu_rsp_ready_i  out/in  1  LSU response handshake
- lsu_rsp_data_o  out  DATA_W  load data; don't-care for stores
- mem_req_valid_o / mem_req_ready_i  out/in  1  memory request handshake
- mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_wstrb_o  out  as above  latched request fields
- mem_rsp_valid_i / mem_rsp_ready_o  in/out  1  memory response handshake
- mem_rsp_data_i  in  DATA_W  response data

## Operation
- The FSM has three states: IDLE, REQ and RESP. Registered state: state_q, owner_q (IFU/LSU), last_q (last granted master), drop_q, and the request fields.
- IDLE, arbitration:
  - If only one master has a valid request, grant it.
  - If both are valid, grant the master that is not last_q (round-robin).
  - While flush_i=1, the IFU is not eligible for a grant.
- IDLE, on a grant:
  - Assert the granted master's req_ready_o combinationally.
  - On that handshake, latch the request fields. An IFU request is latched with we=0 and wstrb=0.
  - Set owner_q and last_q to the granted master, clear drop_q, and go to REQ.
- REQ:
  - mem_req_valid_o=1 and the mem_req_* fields are stable.
  - On mem_req_ready_i, go to RESP.
- RESP, pass-through:
  - owner rsp_valid_o = mem_rsp_valid_i and rsp_data_o = mem_rsp_data_i.
  - mem_rsp_ready_o = owner rsp_ready_i.
  - On the mem response handshake, go to IDLE.
- Stores also receive exactly one response; the LSU must consume it.
- Flush:
  - flush_i in REQ or RESP with owner_q=IFU sets drop_q.
  - While drop_q=1, or while flush_i=1 with owner_q=IFU, ifu_rsp_valid_o=0 and mem_rsp_ready_o=1. The response is absorbed and the FSM returns to IDLE.
  - The bus request is never withdrawn once mem_req_valid_o is high.
  - flush_i has no effect on an LSU-owned transaction.
- The non-owner's req_ready_o and rsp_valid_o stay 0 outside the cases above.

## Timing
- Reset values: all *_ready_o, *_valid_o and mem_req_* outputs are 0; state_q=IDLE, last_q=IFU (so the first tie goes to the LSU), drop_q=0.
- Reset asserted mid-transaction returns the FSM to IDLE immediately. Upstream must also reset the memory side.
- Minimum latency, with mem_req_ready_i and mem_rsp_valid_i already high:
  - Cycle 0: request accepted.
  - Cycle 1: mem_req_valid_o high, accepted.
  - Cycle 2: response delivered.
  - Cycle 3: back in IDLE.
- Peak throughput is one transaction per 3 cycles.
- There are no combinational paths from mem_req_ready_i to any req_ready_o.
- A rsp_ready_i to mem_rsp_ready_o combinational path exists in RESP only.
- Backpressure: mem_req_ready_i=0 holds REQ indefinitely with all fields stable. rsp_ready_i=0 holds RESP indefinitely.
- Simultaneous flush_i and IFU request in IDLE: the IFU is not granted. If the LSU is valid, the LSU is granted.

## Structure
- Add to package liang: arb_state_e {IDLE, REQ, RESP}, arb_master_e {M_IFU, M_LSU}, and mem_req_t (addr, we, wdata, wstrb) for the latched request register.
- One natural sub-module, pipe_arb_rr: a 2-way round-robin picker (valid[1:0], last → grant one-hot), purely combinational.
- The FSM, latches and response routing live in pipe_mem_arb.

## Test plan
- IFU only, addr 0x8000_0000, memory ready and returning 0x0000_0413 → ifu_req_ready_o=1 in cycle 0, mem_req_valid_o in cycle 1 with we=0, ifu_rsp_data_o=0x0000_0413 in cycle 2, IDLE in cycle 3.
- Both masters valid every cycle after reset → grant order LSU, IFU, LSU, IFU; each master's req_ready_o pulses exactly once per 3-cycle transaction.
- LSU store, addr 0x8000_0010, wdata 0xDEAD_BEEF, wstrb 0x3, with mem_req_ready_i low for 4 cycles → mem_req_* fields constant for all 5 REQ cycles, then one lsu_rsp_valid_o.
- IFU fetch with flush_i pulsed in REQ, memory response delayed 3 cycles → ifu_rsp_valid_o never asserts, mem_rsp_ready_o=1 when the response arrives, FSM returns to IDLE, and the next IFU request is served normally.
- LSU load in RESP with lsu_rsp_ready_i low for 2 cycles while flush_i pulses → mem_rsp_ready_o follows lsu_rsp_ready_i and data 0x1234_5678 is delivered once.
- rst_ni asserted during REQ → all outputs 0 on that edge, state IDLE; after release, both masters valid → LSU granted first.

Source files
------------

// File: rtl/pipe_mem_arb_pkg.sv
// Shared types for the two-master memory arbiter: FSM states, master ids and
// the latched memory request record.
package liang;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_STRB_W = MEM_DATA_W / 8;

  typedef logic [MEM_ADDR_W-1:0] paddr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    M_IFU = 1'b0,
    M_LSU = 1'b1
  } arb_master_e;

  typedef struct packed {
    paddr_t                addr;
    logic                  we;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_STRB_W-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/pipe_mem_arb_if.sv
// Bundle of the IFU, LSU and memory-port handshakes; names are from the arbiter's view.
// slave = arbiter side, master = surrounding core / memory environment.
interface pipe_mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              ifu_req_valid_i;
  logic              ifu_req_ready_o;
  logic [ADDR_W-1:0] ifu_req_addr_i;
  logic              ifu_rsp_valid_o;
  logic              ifu_rsp_ready_i;
  logic [DATA_W-1:0] ifu_rsp_data_o;

  logic              lsu_req_valid_i;
  logic              lsu_req_ready_o;
  logic [ADDR_W-1:0] lsu_req_addr_i;
  logic              lsu_req_we_i;
  logic [DATA_W-1:0] lsu_req_wdata_i;
  logic [STRB_W-1:0] lsu_req_wstrb_i;
  logic              lsu_rsp_valid_o;
  logic              lsu_rsp_ready_i;
  logic [DATA_W-1:0] lsu_rsp_data_o;

  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic              mem_req_we_o;
  logic [DATA_W-1:0] mem_req_wdata_o;
  logic [STRB_W-1:0] mem_req_wstrb_o;
  logic              mem_rsp_valid_i;
  logic              mem_rsp_ready_o;
  logic [DATA_W-1:0] mem_rsp_data_i;

  modport slave (
    input  ifu_req_valid_i, ifu_req_addr_i, ifu_rsp_ready_i,
    output ifu_req_ready_o, ifu_rsp_valid_o, ifu_rsp_data_o,
    input  lsu_req_valid_i, lsu_req_addr_i, lsu_req_we_i, lsu_req_wdata_i,
    input  lsu_req_wstrb_i, lsu_rsp_ready_i,
    output lsu_req_ready_o, lsu_rsp_valid_o, lsu_rsp_data_o,
    output mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o,
    output mem_req_wstrb_o, mem_rsp_ready_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i
  );

  modport master (
    output ifu_req_valid_i, ifu_req_addr_i, ifu_rsp_ready_i,
    input  ifu_req_ready_o, ifu_rsp_valid_o, ifu_rsp_data_o,
    output lsu_req_valid_i, lsu_req_addr_i, lsu_req_we_i, lsu_req_wdata_i,
    output lsu_req_wstrb_i, lsu_rsp_ready_i,
    input  lsu_req_ready_o, lsu_rsp_valid_o, lsu_rsp_data_o,
    input  mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o,
    input  mem_req_wstrb_o, mem_rsp_ready_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i
  );

endinterface

// File: rtl/pipe_mem_arb_rr.sv
// Two-way round-robin picker, purely combinational: bit 0 = IFU, bit 1 = LSU.
// On a tie the master that did not win last time is granted.
module pipe_arb_rr
  import liang::*;
(
  input  logic [1:0]  valid_i,
  input  arb_master_e last_i,
  output logic [1:0]  gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (valid_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == M_IFU) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/pipe_mem_arb.sv
// Shares one memory port between IFU and LSU: one transaction in flight, 3-cycle minimum
// (accept, mem request, response); mem/rsp backpressure simply holds REQ/RESP.
module pipe_mem_arb
  import liang::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           flush_i,
  pipe_mem_arb_if.slave  bus
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e  state_q, state_d;
  arb_master_e owner_q, owner_d;
  arb_master_e last_q,  last_d;
  logic        drop_q,  drop_d;
  mem_req_t    req_q,   req_d;

  logic [1:0]        gnt;
  logic              dropping;
  logic              ifu_req_rdy, lsu_req_rdy;
  logic              ifu_rsp_vld, lsu_rsp_vld;
  logic [DATA_W-1:0] ifu_rsp_dat, lsu_rsp_dat;
  logic              mem_req_vld, mem_rsp_rdy;

  // A flushed IFU is simply not a candidate, so a waiting LSU wins outright.
  pipe_arb_rr u_rr (
    .valid_i ({bus.lsu_req_valid_i, bus.ifu_req_valid_i & ~flush_i}),
    .last_i  (last_q),
    .gnt_o   (gnt)
  );

  assign dropping = drop_q | (flush_i & (owner_q == M_IFU));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    drop_d      = drop_q;
    req_d       = req_q;
    ifu_req_rdy = 1'b0;
    lsu_req_rdy = 1'b0;
    ifu_rsp_vld = 1'b0;
    lsu_rsp_vld = 1'b0;
    ifu_rsp_dat = '0;
    lsu_rsp_dat = '0;
    mem_req_vld = 1'b0;
    mem_rsp_rdy = 1'b0;

    case (state_q)
      IDLE: begin
        ifu_req_rdy = gnt[0];
        lsu_req_rdy = gnt[1];
        if (gnt[0]) begin
          req_d.addr  = bus.ifu_req_addr_i;
          req_d.we    = 1'b0;
          req_d.wdata = '0;
          req_d.wstrb = '0;
          owner_d     = M_IFU;
          last_d      = M_IFU;
          drop_d      = 1'b0;
          state_d     = REQ;
        end else if (gnt[1]) begin
          req_d.addr  = bus.lsu_req_addr_i;
          req_d.we    = bus.lsu_req_we_i;
          req_d.wdata = bus.lsu_req_wdata_i;
          req_d.wstrb = bus.lsu_req_wstrb_i;
          owner_d     = M_LSU;
          last_d      = M_LSU;
          drop_d      = 1'b0;
          state_d     = REQ;
        end
      end

      // The bus request stays up even when flushed; only the response is discarded.
      REQ: begin
        mem_req_vld = 1'b1;
        if (flush_i && owner_q == M_IFU) drop_d = 1'b1;
        if (bus.mem_req_ready_i) state_d = RESP;
      end

      RESP: begin
        if (flush_i && owner_q == M_IFU) drop_d = 1'b1;
        if (dropping) begin
          mem_rsp_rdy = 1'b1;
        end else if (owner_q == M_IFU) begin
          ifu_rsp_vld = bus.mem_rsp_valid_i;
          ifu_rsp_dat = bus.mem_rsp_data_i;
          mem_rsp_rdy = bus.ifu_rsp_ready_i;
        end else begin
          lsu_rsp_vld = bus.mem_rsp_valid_i;
          lsu_rsp_dat = bus.mem_rsp_data_i;
          mem_rsp_rdy = bus.lsu_rsp_ready_i;
        end
        if (bus.mem_rsp_valid_i && mem_rsp_rdy) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= M_IFU;
      last_q  <= M_IFU;
      drop_q  <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
    end
  end

  assign bus.ifu_req_ready_o = ifu_req_rdy;
  assign bus.lsu_req_ready_o = lsu_req_rdy;
  assign bus.ifu_rsp_valid_o = ifu_rsp_vld;
  assign bus.lsu_rsp_valid_o = lsu_rsp_vld;
  assign bus.ifu_rsp_data_o  = ifu_rsp_dat;
  assign bus.lsu_rsp_data_o  = lsu_rsp_dat;
  assign bus.mem_req_valid_o = mem_req_vld;
  assign bus.mem_rsp_ready_o = mem_rsp_rdy;

  assign bus.mem_req_addr_o  = ADDR_W'(req_q.addr);
  assign bus.mem_req_we_o    = req_q.we;
  assign bus.mem_req_wdata_o = DATA_W'(req_q.wdata);
  assign bus.mem_req_wstrb_o = STRB_W'(req_q.wstrb);

endmodule

// File: tb/tb_pipe_mem_arb.sv
// Directed bench for pipe_mem_arb: fetch, round-robin, stalled store, flushed fetch,
// held LSU response and mid-transaction reset.
module tb_pipe_mem_arb;
  import liang::*;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;

  pipe_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  pipe_mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    flush  = 1'b0;
    bus.ifu_req_valid_i = 1'b0;
    bus.ifu_req_addr_i  = '0;
    bus.ifu_rsp_ready_i = 1'b0;
    bus.lsu_req_valid_i = 1'b0;
    bus.lsu_req_addr_i  = '0;
    bus.lsu_req_we_i    = 1'b0;
    bus.lsu_req_wdata_i = '0;
    bus.lsu_req_wstrb_i = '0;
    bus.lsu_rsp_ready_i = 1'b0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = '0;

    // Reset state
    #12;
    chk("rst_state", dut.state_q, IDLE);
    chk("rst_mem_req_valid", bus.mem_req_valid_o, 1'b0);
    chk("rst_mem_req_addr", bus.mem_req_addr_o, 32'h0);
    chk("rst_mem_rsp_ready", bus.mem_rsp_ready_o, 1'b0);
    chk("rst_ifu_rsp_valid", bus.ifu_rsp_valid_o, 1'b0);
    chk("rst_lsu_rsp_valid", bus.lsu_rsp_valid_o, 1'b0);
    rst_n = 1'b1;

    // IFU-only fetch at minimum latency
    cyc();
    bus.mem_req_ready_i = 1'b1;
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_data_i  = 32'h0000_0413;
    bus.ifu_rsp_ready_i = 1'b1;
    bus.lsu_rsp_ready_i = 1'b1;
    bus.ifu_req_valid_i = 1'b1;
    bus.ifu_req_addr_i  = 32'h8000_0000;
    #1;
    chk("f_c0_ifu_ready", bus.ifu_req_ready_o, 1'b1);
    chk("f_c0_lsu_ready", bus.lsu_req_ready_o, 1'b0);
    chk("f_c0_mem_valid", bus.mem_req_valid_o, 1'b0);
    cyc();
    bus.ifu_req_valid_i = 1'b0;
    #1;
    chk("f_c1_mem_valid", bus.mem_req_valid_o, 1'b1);
    chk("f_c1_mem_we", bus.mem_req_we_o, 1'b0);
    chk("f_c1_mem_wstrb", bus.mem_req_wstrb_o, 4'h0);
    chk("f_c1_mem_addr", bus.mem_req_addr_o, 32'h8000_0000);
    chk("f_c1_ifu_ready", bus.ifu_req_ready_o, 1'b0);
    cyc();
    chk("f_c2_ifu_rsp_valid", bus.ifu_rsp_valid_o, 1'b1);
    chk("f_c2_ifu_rsp_data", bus.ifu_rsp_data_o, 32'h0000_0413);
    chk("f_c2_mem_rsp_ready", bus.mem_rsp_ready_o, 1'b1);
    chk("f_c2_lsu_rsp_valid", bus.lsu_rsp_valid_o, 1'b0);
    cyc();
    chk("f_c3_state", dut.state_q, IDLE);
    chk("f_c3_ifu_rsp_valid", bus.ifu_rsp_valid_o, 1'b0);

    // Both masters valid continuously: LSU, IFU, LSU, IFU
    bus.ifu_req_valid_i = 1'b1;
    bus.ifu_req_addr_i  = 32'h0000_0200;
    bus.lsu_req_valid_i = 1'b1;
    bus.lsu_req_addr_i  = 32'h0000_0100;
    bus.lsu_req_we_i    = 1'b0;
    #1;
    for (int t = 0; t < 4; t++) begin
      logic lsu_wins;
      lsu_wins = (t % 2 == 0);
      chk($sformatf("rr%0d_c0_lsu_ready", t), bus.lsu_req_ready_o, lsu_wins);
      chk($sformatf("rr%0d_c0_ifu_ready", t), bus.ifu_req_ready_o, !lsu_wins);
      cyc();
      chk($sformatf("rr%0d_c1_readies", t), {bus.lsu_req_ready_o, bus.ifu_req_ready_o}, 2'b00);
      chk($sformatf("rr%0d_c1_addr", t), bus.mem_req_addr_o,
          lsu_wins ? 32'h0000_0100 : 32'h0000_0200);
      cyc();
      chk($sformatf("rr%0d_c2_readies", t), {bus.lsu_req_ready_o, bus.ifu_req_ready_o}, 2'b00);
      chk($sformatf("rr%0d_c2_lsu_rsp", t), bus.lsu_rsp_valid_o, lsu_wins);
      chk($sformatf("rr%0d_c2_ifu_rsp", t), bus.ifu_rsp_valid_o, !lsu_wins);
      cyc();
    end
    bus.ifu_req_valid_i = 1'b0;
    bus.lsu_req_valid_i = 1'b0;
    #1;

    // LSU store with memory stalled for 4 cycles
    bus.mem_req_ready_i = 1'b0;
    bus.lsu_req_valid_i = 1'b1;
    bus.lsu_req_addr_i  = 32'h8000_0010;
    bus.lsu_req_we_i    = 1'b1;
    bus.lsu_req_wdata_i = 32'hDEAD_BEEF;
    bus.lsu_req_wstrb_i = 4'h3;
    #1;
    chk("st_c0_lsu_ready", bus.lsu_req_ready_o, 1'b1);
    cyc();
    bus.lsu_req_valid_i = 1'b0;
    bus.lsu_req_addr_i  = 32'h1111_1111;
    bus.lsu_req_we_i    = 1'b0;
    bus.lsu_req_wdata_i = 32'h2222_2222;
    bus.lsu_req_wstrb_i = 4'hC;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.mem_req_ready_i = 1'b1;
      #1;
      chk($sformatf("st_req%0d_valid", i), bus.mem_req_valid_o, 1'b1);
      chk($sformatf("st_req%0d_addr", i), bus.mem_req_addr_o, 32'h8000_0010);
      chk($sformatf("st_req%0d_we", i), bus.mem_req_we_o, 1'b1);
      chk($sformatf("st_req%0d_wdata", i), bus.mem_req_wdata_o, 32'hDEAD_BEEF);
      chk($sformatf("st_req%0d_wstrb", i), bus.mem_req_wstrb_o, 4'h3);
      chk($sformatf("st_req%0d_lsu_rsp", i), bus.lsu_rsp_valid_o, 1'b0);
      cyc();
    end
    chk("st_rsp_lsu_valid", bus.lsu_rsp_valid_o, 1'b1);
    chk("st_rsp_ifu_valid", bus.ifu_rsp_valid_o, 1'b0);
    cyc();
    chk("st_done_state", dut.state_q, IDLE);
    chk("st_done_lsu_valid", bus.lsu_rsp_valid_o, 1'b0);

    // IFU fetch flushed in REQ, response arrives 3 cycles later
    bus.mem_rsp_valid_i = 1'b0;
    bus.ifu_req_valid_i = 1'b1;
    bus.ifu_req_addr_i  = 32'h8000_0004;
    #1;
    chk("fl_c0_ifu_ready", bus.ifu_req_ready_o, 1'b1);
    cyc();
    bus.ifu_req_valid_i = 1'b0;
    flush = 1'b1;
    #1;
    chk("fl_req_mem_valid", bus.mem_req_valid_o, 1'b1);
    chk("fl_req_state", dut.state_q, REQ);
    cyc();
    flush = 1'b0;
    #1;
    chk("fl_wait1_ifu_rsp", bus.ifu_rsp_valid_o, 1'b0);
    chk("fl_wait1_state", dut.state_q, RESP);
    cyc();
    chk("fl_wait2_ifu_rsp", bus.ifu_rsp_valid_o, 1'b0);
    cyc();
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_data_i  = 32'hBAD0_BAD0;
    #1;
    chk("fl_arrive_ifu_rsp", bus.ifu_rsp_valid_o, 1'b0);
    chk("fl_arrive_mem_ready", bus.mem_rsp_ready_o, 1'b1);
    cyc();
    chk("fl_done_state", dut.state_q, IDLE);
    chk("fl_done_ifu_rsp", bus.ifu_rsp_valid_o, 1'b0);
    bus.mem_rsp_data_i  = 32'h0000_0013;
    bus.ifu_req_valid_i = 1'b1;
    bus.ifu_req_addr_i  = 32'h8000_0008;
    #1;
    chk("fl_next_ifu_ready", bus.ifu_req_ready_o, 1'b1);
    cyc();
    bus.ifu_req_valid_i = 1'b0;
    #1;
    chk("fl_next_mem_addr", bus.mem_req_addr_o, 32'h8000_0008);
    cyc();
    chk("fl_next_ifu_rsp", bus.ifu_rsp_valid_o, 1'b1);
    chk("fl_next_ifu_data", bus.ifu_rsp_data_o, 32'h0000_0013);
    cyc();
    chk("fl_next_state", dut.state_q, IDLE);

    // LSU load held in RESP by lsu_rsp_ready while flush pulses
    bus.mem_rsp_data_i  = 32'h1234_5678;
    bus.lsu_rsp_ready_i = 1'b0;
    bus.lsu_req_valid_i = 1'b1;
    bus.lsu_req_addr_i  = 32'h8000_0020;
    bus.lsu_req_we_i    = 1'b0;
    #1;
    chk("ld_c0_lsu_ready", bus.lsu_req_ready_o, 1'b1);
    cyc();
    bus.lsu_req_valid_i = 1'b0;
    cyc();
    flush = 1'b1;
    #1;
    chk("ld_hold1_valid", bus.lsu_rsp_valid_o, 1'b1);
    chk("ld_hold1_data", bus.lsu_rsp_data_o, 32'h1234_5678);
    chk("ld_hold1_mem_ready", bus.mem_rsp_ready_o, 1'b0);
    cyc();
    flush = 1'b0;
    #1;
    chk("ld_hold2_valid", bus.lsu_rsp_valid_o, 1'b1);
    chk("ld_hold2_mem_ready", bus.mem_rsp_ready_o, 1'b0);
    chk("ld_hold2_state", dut.state_q, RESP);
    bus.lsu_rsp_ready_i = 1'b1;
    #1;
    chk("ld_take_mem_ready", bus.mem_rsp_ready_o, 1'b1);
    chk("ld_take_data", bus.lsu_rsp_data_o, 32'h1234_5678);
    cyc();
    chk("ld_done_state", dut.state_q, IDLE);
    chk("ld_done_valid", bus.lsu_rsp_valid_o, 1'b0);

    // Reset during REQ, then tie after release goes to the LSU
    bus.mem_req_ready_i = 1'b0;
    bus.ifu_req_valid_i = 1'b1;
    bus.ifu_req_addr_i  = 32'h8000_0030;
    cyc();
    bus.ifu_req_valid_i = 1'b0;
    #1;
    chk("rr_pre_mem_valid", bus.mem_req_valid_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rr_state", dut.state_q, IDLE);
    chk("rr_mem_valid", bus.mem_req_valid_o, 1'b0);
    chk("rr_mem_addr", bus.mem_req_addr_o, 32'h0);
    chk("rr_readies", {bus.ifu_req_ready_o, bus.lsu_req_ready_o, bus.mem_rsp_ready_o}, 3'b000);
    chk("rr_rsp_valids", {bus.ifu_rsp_valid_o, bus.lsu_rsp_valid_o}, 2'b00);
    cyc();
    rst_n = 1'b1;
    bus.ifu_req_valid_i = 1'b1;
    bus.lsu_req_valid_i = 1'b1;
    bus.lsu_req_addr_i  = 32'h8000_0040;
    #1;
    chk("rr_tie_lsu_ready", bus.lsu_req_ready_o, 1'b1);
    chk("rr_tie_ifu_ready", bus.ifu_req_ready_o, 1'b0);
    cyc();
    bus.ifu_req_valid_i = 1'b0;
    bus.lsu_req_valid_i = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    #1;
    chk("rr_tie_mem_addr", bus.mem_req_addr_o, 32'h8000_0040);
    cyc();
    cyc();
    chk("rr_end_state", dut.state_q, IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
